// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA), the arbiter and the single-port RAM.
// The arbiter attaches through the slave modport; requesters and RAM model use master.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_done;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_done;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_err;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_done, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_done, dma_rdata, dma_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_done, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_done, dma_rdata, dma_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter and access sequencer for a single-port synchronous RAM.
// Define ARB_PROTECT_EN to block DMA writes below PROT_LIMIT (reported on dma_err).
module mem_arbiter #(
   parameter int unsigned       ADDR_W     = 8,
   parameter int unsigned       DATA_W     = 8,
   parameter logic [ADDR_W-1:0] PROT_LIMIT = ADDR_W'(8'h20)
) (
   input logic          Clk,
   input logic          Reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle,
      StCpuAcc,
      StCpuDone,
      StDmaAcc,
      StDmaDone
   } state_e;

   state_e            state_q, state_d;
   logic              we_q;
   logic              blk_q;
   logic              dma_blocked;
   logic [DATA_W-1:0] cpu_hold_q;
   logic [DATA_W-1:0] dma_hold_q;

`ifdef ARB_PROTECT_EN
   assign dma_blocked = bus.dma_we && (bus.dma_addr < PROT_LIMIT);
`else
   assign dma_blocked = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // The finishing port's own request is ignored in _DONE so the other port gets a turn.
   always_comb begin
      state_d = StIdle;
      unique case (state_q)
         StIdle: begin
            if (bus.cpu_req) begin
               state_d = StCpuAcc;
            end else if (bus.dma_req) begin
               state_d = StDmaAcc;
            end else begin
               state_d = StIdle;
            end
         end
         StCpuAcc:  state_d = StCpuDone;
         StCpuDone: state_d = bus.dma_req ? StDmaAcc : StIdle;
         StDmaAcc:  state_d = StDmaDone;
         StDmaDone: state_d = bus.cpu_req ? StCpuAcc : StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Access attributes captured on entry to an _ACC state keep the outputs state-decoded.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         we_q  <= 1'b0;
         blk_q <= 1'b0;
      end else if (state_d == StCpuAcc) begin
         we_q  <= bus.cpu_we;
         blk_q <= 1'b0;
      end else if (state_d == StDmaAcc) begin
         we_q  <= bus.dma_we;
         blk_q <= dma_blocked;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cpu_hold_q <= '0;
         dma_hold_q <= '0;
      end else begin
         if (state_q == StCpuDone && !we_q) begin
            cpu_hold_q <= bus.mem_rdata;
         end
         if (state_q == StDmaDone && !we_q) begin
            dma_hold_q <= bus.mem_rdata;
         end
      end
   end

   always_comb begin
      bus.cpu_gnt   = 1'b0;
      bus.cpu_done  = 1'b0;
      bus.cpu_rdata = cpu_hold_q;
      bus.dma_gnt   = 1'b0;
      bus.dma_done  = 1'b0;
      bus.dma_rdata = dma_hold_q;
      bus.dma_err   = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      unique case (state_q)
         StCpuAcc: begin
            bus.cpu_gnt   = 1'b1;
            bus.mem_en    = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
         end
         StCpuDone: begin
            bus.cpu_done = 1'b1;
            if (!we_q) begin
               bus.cpu_rdata = bus.mem_rdata;
            end
         end
         StDmaAcc: begin
            bus.dma_gnt = 1'b1;
            if (!blk_q) begin
               bus.mem_en    = 1'b1;
               bus.mem_we    = we_q;
               bus.mem_addr  = bus.dma_addr;
               bus.mem_wdata = bus.dma_wdata;
            end
         end
         StDmaDone: begin
            bus.dma_done = 1'b1;
`ifdef ARB_PROTECT_EN
            bus.dma_err  = blk_q;
`else
            bus.dma_err  = 1'b0;
`endif
            if (!we_q) begin
               bus.dma_rdata = bus.mem_rdata;
            end
         end
         default: begin
            bus.cpu_gnt = 1'b0;
         end
      endcase
   end

endmodule
